// File: rtl/dpram_fifo_ctrl_if.sv
// User-facing push/pop interface of the FIFO controller.
// master = producer/consumer side, slave = FIFO controller side.
interface dpram_fifo_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);
    // Handshake: a push is taken on a rising clk edge when wr_en=1 and full=0;
    // a pop is taken when rd_en=1 and empty=0, and its data appears with
    // rd_valid=1 exactly one cycle later. Rejected requests only raise the
    // overflow/underflow pulse on the following cycle.
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// Synchronous FIFO controller driving an external dual-port RAM:
// port A is write-only, port B is read-only with one cycle of read latency.
module dpram_fifo_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 6,
    parameter int AF_LEVEL = 60
) (
    input  logic                clk,
    input  logic                rst_n,
    dpram_fifo_ctrl_if.slave    fifo,
    output logic [DATA_W-1:0]   ram_data_a,
    output logic [ADDR_W-1:0]   ram_addr_a,
    output logic                ram_we_a,
    output logic [DATA_W-1:0]   ram_data_b,
    output logic [ADDR_W-1:0]   ram_addr_b,
    output logic                ram_we_b,
    input  logic [DATA_W-1:0]   ram_q_b
);
    localparam logic [ADDR_W:0] AF_CNT  = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] occ;
    logic            full_s;
    logic            empty_s;
    logic            wa;
    logic            ra;
    logic            rd_valid_q;
    logic            ovf_q;
    logic            udf_q;

    assign occ     = wr_ptr - rd_ptr;
    assign empty_s = (wr_ptr == rd_ptr);
    assign full_s  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

    // rst_n gates the write strobe so the RAM sees no write while reset is held.
    assign wa = fifo.wr_en & ~full_s & rst_n;
    assign ra = fifo.rd_en & ~empty_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            if (wa) wr_ptr <= wr_ptr + PTR_ONE;
            if (ra) rd_ptr <= rd_ptr + PTR_ONE;
            rd_valid_q <= ra;
            ovf_q      <= fifo.wr_en & full_s;
            udf_q      <= fifo.rd_en & empty_s;
        end
    end

    assign ram_we_a   = wa;
    assign ram_addr_a = wr_ptr[ADDR_W-1:0];
    assign ram_data_a = fifo.wr_data;
    assign ram_we_b   = 1'b0;
    assign ram_data_b = '0;
    assign ram_addr_b = rd_ptr[ADDR_W-1:0];

    assign fifo.rd_data     = ram_q_b;
    assign fifo.rd_valid    = rd_valid_q;
    assign fifo.full        = full_s;
    assign fifo.empty       = empty_s;
    assign fifo.almost_full = (occ >= AF_CNT);
    assign fifo.count       = occ;
    assign fifo.overflow    = ovf_q;
    assign fifo.underflow   = udf_q;
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl: RAM model, queue-based reference model,
// per-cycle compare process and directed/random scenarios.
module tb_dpram_fifo_ctrl;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 6;
    localparam int DEPTH    = 64;
    localparam int AF_LEVEL = 60;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dpram_fifo_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) fif ();

    logic [DATA_W-1:0] ram_data_a, ram_data_b, ram_q_b;
    logic [ADDR_W-1:0] ram_addr_a, ram_addr_b;
    logic              ram_we_a, ram_we_b;

    dpram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AF_LEVEL(AF_LEVEL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo       (fif),
        .ram_data_a (ram_data_a),
        .ram_addr_a (ram_addr_a),
        .ram_we_a   (ram_we_a),
        .ram_data_b (ram_data_b),
        .ram_addr_b (ram_addr_b),
        .ram_we_b   (ram_we_b),
        .ram_q_b    (ram_q_b)
    );

    // Behavioural dual_port_ram: registered read on port B.
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
        ram_q_b <= mem[ram_addr_b];
    end

    // ---------------- scoreboard / reference model ----------------
    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic              exp_rd_valid = 1'b0;
    logic [DATA_W-1:0] exp_rd_data  = '0;
    logic              exp_ovf      = 1'b0;
    logic              exp_udf      = 1'b0;
    int                wr_total     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin : model
        int  n;
        bit  acc_w, acc_r;
        if (!rst_n) begin
            exp_q.delete();
            exp_rd_valid = 1'b0;
            exp_ovf      = 1'b0;
            exp_udf      = 1'b0;
            wr_total     = 0;
        end else begin
            n     = exp_q.size();
            acc_r = fif.rd_en && (n > 0);
            acc_w = fif.wr_en && (n < DEPTH);
            exp_ovf      = fif.wr_en && (n == DEPTH);
            exp_udf      = fif.rd_en && (n == 0);
            exp_rd_valid = acc_r;
            if (acc_r) exp_rd_data = exp_q.pop_front();
            if (acc_w) begin
                exp_q.push_back(fif.wr_data);
                wr_total++;
            end
        end
    end

    // Compare process: every output against the model, away from the active edge.
    always @(negedge clk) begin : compare
        int  n;
        bit  exp_we;
        n      = exp_q.size();
        exp_we = rst_n && fif.wr_en && (n < DEPTH);
        chk("count",       32'(fif.count),       32'(n));
        chk("full",        32'(fif.full),        32'(n == DEPTH));
        chk("empty",       32'(fif.empty),       32'(n == 0));
        chk("almost_full", 32'(fif.almost_full), 32'(n >= AF_LEVEL));
        chk("rd_valid",    32'(fif.rd_valid),    32'(exp_rd_valid));
        if (exp_rd_valid) chk("rd_data", 32'(fif.rd_data), 32'(exp_rd_data));
        chk("overflow",    32'(fif.overflow),    32'(exp_ovf));
        chk("underflow",   32'(fif.underflow),   32'(exp_udf));
        chk("ram_we_a",    32'(ram_we_a),        32'(exp_we));
        if (exp_we) begin
            chk("ram_addr_a", 32'(ram_addr_a), 32'(wr_total % DEPTH));
            chk("ram_data_a", 32'(ram_data_a), 32'(fif.wr_data));
        end
        if (n > 0) chk("ram_addr_b", 32'(ram_addr_b), 32'((wr_total - n) % DEPTH));
        chk("ram_we_b",    32'(ram_we_b),   32'd0);
        chk("ram_data_b",  32'(ram_data_b), 32'd0);
    end

    // ---------------- driver tasks ----------------
    // Inputs change 2 time units after a rising edge; the call returns 2 units
    // after the edge that consumed them.
    task automatic drive(input logic we, input logic [DATA_W-1:0] wd, input logic re);
        fif.wr_en   = we;
        fif.wr_data = wd;
        fif.rd_en   = re;
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        for (int k = 0; k < DEPTH + 4 && exp_q.size() > 0; k++) drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b0);
    endtask

    task automatic random_phase(input int cycles, input int wr_pct, input int rd_pct);
        for (int k = 0; k < cycles; k++)
            drive($urandom_range(0, 99) < wr_pct, DATA_W'($urandom), $urandom_range(0, 99) < rd_pct);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [DATA_W-1:0] last1, last0;
        int n;
        fif.wr_en = 1'b0; fif.wr_data = '0; fif.rd_en = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_count", 32'(fif.count), 32'd0);
        chk("rst_empty", 32'(fif.empty), 32'd1);
        chk("rst_full",  32'(fif.full),  32'd0);
        chk("rst_af",    32'(fif.almost_full), 32'd0);
        chk("rst_rd_valid", 32'(fif.rd_valid), 32'd0);
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b0);

        // Fill with 0x00..0x3F.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, DATA_W'(i), 1'b0);
            if (i == 58) chk("af_at_59", 32'(fif.almost_full), 32'd0);
            if (i == 59) chk("af_at_60", 32'(fif.almost_full), 32'd1);
        end
        chk("fill_count", 32'(fif.count), 32'd64);
        chk("fill_full",  32'(fif.full),  32'd1);

        // Write attempt while full.
        fif.wr_en = 1'b1; fif.wr_data = 8'hAA; fif.rd_en = 1'b0;
        #1;
        chk("ovf_we_a", 32'(ram_we_a), 32'd0);
        @(posedge clk); #2;
        chk("ovf_pulse", 32'(fif.overflow), 32'd1);
        chk("ovf_count", 32'(fif.count),    32'd64);
        drive(1'b0, '0, 1'b0);
        chk("ovf_end", 32'(fif.overflow), 32'd0);

        // Drain in order, then one read too many.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, '0, 1'b1);
            chk("drain_valid", 32'(fif.rd_valid), 32'd1);
            chk("drain_data",  32'(fif.rd_data),  32'(i));
        end
        chk("drain_empty", 32'(fif.empty), 32'd1);
        drive(1'b0, '0, 1'b1);
        chk("udf_pulse", 32'(fif.underflow), 32'd1);
        chk("udf_valid", 32'(fif.rd_valid),  32'd0);
        drive(1'b0, '0, 1'b0);

        // Count 5 with simultaneous push/pop.
        for (int i = 0; i < 5; i++) drive(1'b1, DATA_W'($urandom), 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, DATA_W'($urandom), 1'b1);
            chk("sim_count", 32'(fif.count), 32'd5);
        end
        drain();

        // Interleaved random traffic across pointer wrap, then biased phases.
        random_phase(200, 50, 50);
        random_phase(150, 80, 30);
        random_phase(150, 30, 80);
        drain();

        // Place 0x33 at slot 63 and 0x44 at slot 0.
        for (int k = 0; k < DEPTH && (wr_total % DEPTH) != 63; k++) drive(1'b1, DATA_W'($urandom), 1'b0);
        drive(1'b1, 8'h33, 1'b0);
        drive(1'b1, 8'h44, 1'b0);
        n = exp_q.size();
        last1 = '0; last0 = '0;
        for (int k = 0; k < n; k++) begin
            drive(1'b0, '0, 1'b1);
            last1 = last0;
            last0 = fif.rd_data;
        end
        chk("wrap_slot63", 32'(last1), 32'h33);
        chk("wrap_slot0",  32'(last0), 32'h44);
        drive(1'b0, '0, 1'b0);

        // Asynchronous reset at count 20 with a write pending.
        for (int i = 0; i < 20; i++) drive(1'b1, DATA_W'($urandom), 1'b0);
        chk("pre_rst_count", 32'(fif.count), 32'd20);
        fif.wr_en = 1'b1; fif.wr_data = DATA_W'($urandom);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(fif.count), 32'd0);
        chk("arst_empty", 32'(fif.empty), 32'd1);
        chk("arst_full",  32'(fif.full),  32'd0);
        chk("arst_af",    32'(fif.almost_full), 32'd0);
        chk("arst_we_a",  32'(ram_we_a),  32'd0);
        @(posedge clk); #2;
        chk("arst_we_a_edge", 32'(ram_we_a), 32'd0);
        chk("arst_count_edge", 32'(fif.count), 32'd0);
        fif.wr_en = 1'b0;
        rst_n = 1'b1;
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b0, '0, 1'b1);
        chk("post_rst_valid", 32'(fif.rd_valid), 32'd1);
        chk("post_rst_data",  32'(fif.rd_data),  32'h55);
        drive(1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
